// File: rtl/montgomery_mult.sv
// Radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M.
// One iteration per enabled clock, then a final conditional subtract.
module montgomery_mult #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    // S stays below 2M; T + q*M stays below 4M, one spare bit on top.
    localparam int SW = WIDTH + 2;
    localparam int TW = WIDTH + 3;
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINAL
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [CW-1:0]    i_q, i_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [TW-1:0]    t_w;
    logic [TW-1:0]    u_w;
    logic [SW-1:0]    s_iter;
    logic [WIDTH-1:0] diff_w;
    logic             s_ge_m;

    // Datapath for one iteration and for the final reduction.
    always_comb begin
        t_w    = {1'b0, s_q} + (a_q[0] ? {3'b000, b_q} : '0);
        u_w    = t_w + (t_w[0] ? {3'b000, m_q} : '0);
        s_iter = SW'(u_w >> 1);
        s_ge_m = (s_q >= {2'b00, m_q});
        diff_w = s_q[WIDTH-1:0] - m_q;
    end

    // Next-state logic; everything holds while en is low except done.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        i_d      = i_q;
        a_d      = a_q;
        b_d      = b_q;
        m_d      = m_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_d     = a;
                        b_d     = b;
                        m_d     = m;
                        s_d     = '0;
                        i_d     = '0;
                        state_d = CALC;
                        busy_d  = 1'b1;
                    end
                end
                CALC: begin
                    s_d = s_iter;
                    a_d = a_q >> 1;
                    i_d = i_q + CW'(1);
                    if (i_q == CW'(WIDTH - 1)) begin
                        state_d = FINAL;
                    end
                end
                FINAL: begin
                    result_d = s_ge_m ? diff_w : s_q[WIDTH-1:0];
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= IDLE;
            s_q      <= '0;
            i_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            i_q      <= i_d;
            a_q      <= a_d;
            b_q      <= b_d;
            m_q      <= m_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_montgomery_mult.sv
// Bench for montgomery_mult: directed cases plus random odd moduli,
// scoreboard queue checked by a done monitor.
module tb_montgomery_mult;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rstb;
    logic         en;
    logic         start;
    logic [W-1:0] a, b, m;
    logic [W-1:0] result;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic done_prev = 1'b0;

    typedef struct {
        logic [W-1:0] res;
        int           c0;
        int           lat;
        bit           care;
    } exp_t;

    exp_t exp_q[$];

    montgomery_mult #(.WIDTH(W)) dut (
        .clk(clk), .rstb(rstb), .en(en), .start(start),
        .a(a), .b(b), .m(m),
        .result(result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] mont_ref(int ai, int bi, int mi);
        int p;
        p = (ai * bi) % mi;
        for (int r = 0; r < mi; r++)
            if (((r * (1 << W)) % mi) == p) return W'(r);
        return '0;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rstb) begin
            if (done && done_prev) begin
                checks++;
                errors++;
                $display("FAIL done_width got 2 expected 1");
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got 1 expected 0");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.care) chk("result", int'(result), int'(e.res));
                    chk("latency", cyc - e.c0, e.lat);
                end
            end
        end
        done_prev = done;
    end

    task automatic run_op(input int ai, input int bi, input int mi,
                          input bit care, input bit sync,
                          input int pause_at, input int pause_len,
                          input bit glitch);
        exp_t e;
        int n;
        int busy_n;
        bit got;
        if (!sync) @(negedge clk);
        a = W'(ai);
        b = W'(bi);
        m = W'(mi);
        start = 1'b1;
        @(posedge clk);
        #1;
        e.res  = care ? mont_ref(ai, bi, mi) : '0;
        e.c0   = cyc;
        e.lat  = W + 1 + ((pause_at > 0) ? pause_len : 0);
        e.care = care;
        exp_q.push_back(e);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        m = W'($urandom);
        n = 0;
        busy_n = 0;
        got = 1'b0;
        while (n < 60 && !got) begin
            @(negedge clk);
            n++;
            if (done) begin
                got = 1'b1;
                start = 1'b0;
            end else begin
                if (busy) busy_n++;
                if (pause_at > 0 && n == pause_at) en = 1'b0;
                if (pause_at > 0 && n == pause_at + pause_len) en = 1'b1;
                start = (glitch && n == 7);
            end
        end
        en = 1'b1;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got 0 expected 1");
        end
        chk("busy_cycles", busy_n, e.lat);
    endtask

    initial begin
        int mi, ai, bi;
        rstb = 1'b0;
        en = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        m = '0;
        repeat (2) @(negedge clk);
        chk("rst_result", int'(result), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rstb = 1'b1;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        run_op(100, 17, 239, 1'b1, 1'b0, 0, 0, 1'b0);
        chk("dir_100", int'(result), 100);
        run_op(50, 1, 239, 1'b1, 1'b0, 0, 0, 1'b0);
        chk("dir_17", int'(result), 17);
        run_op(254, 254, 255, 1'b1, 1'b0, 0, 0, 1'b0);
        chk("dir_1", int'(result), 1);
        run_op(0, 200, 239, 1'b1, 1'b0, 0, 0, 1'b0);
        chk("dir_0", int'(result), 0);

        run_op(123, 45, 239, 1'b1, 1'b0, 3, 3, 1'b1);
        repeat (15) @(negedge clk);
        chk("no_second_done", exp_q.size(), 0);
        chk("idle_after_glitch", int'(busy), 0);
        chk("result_hold", int'(result), int'(mont_ref(123, 45, 239)));

        run_op(77, 150, 200, 1'b0, 1'b0, 0, 0, 1'b0);

        @(negedge clk);
        a = 8'd9;
        b = 8'd8;
        m = 8'd239;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rstb = 1'b0;
        #1;
        chk("midrst_result", int'(result), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b1;
        repeat (14) @(negedge clk);
        chk("no_resume_busy", int'(busy), 0);
        chk("no_resume_result", int'(result), 0);
        run_op(100, 17, 239, 1'b1, 1'b0, 0, 0, 1'b0);
        chk("post_rst_100", int'(result), 100);

        for (int k = 0; k < 1000; k++) begin
            mi = int'($urandom_range(1, 255)) | 1;
            ai = int'($urandom_range(0, mi - 1));
            bi = int'($urandom_range(0, mi - 1));
            run_op(ai, bi, mi, 1'b1, (k > 0), 0, 0, 1'b0);
        end

        repeat (15) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
